// File: rtl/cim_tile_pkg.sv
// Shared widths, pipeline side-band type and saturation helpers for the CIM tile MAC.
// Saturation helpers are used only when CIM_TILE_SAT_EN is defined.
package cim_tile_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } sb_t;

    function automatic int prod_w(input int x_w, input int w_w);
        return x_w + w_w;
    endfunction

    function automatic int sum_w(input int x_w, input int w_w, input int row_num);
        return prod_w(x_w, w_w) + $clog2(row_num);
    endfunction

    function automatic int acc_w(input int x_w, input int w_w, input int row_num, input int beats);
        return sum_w(x_w, w_w, row_num) + $clog2(beats);
    endfunction

    function automatic int col_aw(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Clamp a sign-extended value into the signed ow-bit range.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int unsigned ow);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (ow - 32'd1)) - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < ~hi) begin
            return ~hi;
        end else begin
            return v;
        end
    endfunction

    function automatic logic sat_clip(input logic signed [63:0] v, input int unsigned ow);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (ow - 32'd1)) - 64'sd1;
        return (v > hi) || (v < ~hi);
    endfunction

endpackage

// File: rtl/cim_tile_mac_if.sv
// Input-beat and result stream bundle of the CIM tile MAC.
// out_sat exists only when CIM_TILE_SAT_EN is defined.
interface cim_tile_mac_if #(
    parameter int ROW_NUM   = 16,
    parameter int COL_NUM   = 4,
    parameter int X_W       = 8,
    parameter int OUT_W     = 24,
    parameter int MEM_DEPTH = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [ROW_NUM*X_W-1:0]         in_x;
    logic [$clog2(MEM_DEPTH)-1:0]   in_adr;
    logic                           in_first;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [COL_NUM*OUT_W-1:0]       out_q;
`ifdef CIM_TILE_SAT_EN
    logic [COL_NUM-1:0]             out_sat;

    modport master (
        output in_valid, in_x, in_adr, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_q, out_sat
    );
    modport slave (
        input  in_valid, in_x, in_adr, in_first, in_last, out_ready,
        output in_ready, out_valid, out_q, out_sat
    );
`else
    modport master (
        output in_valid, in_x, in_adr, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_q
    );
    modport slave (
        input  in_valid, in_x, in_adr, in_first, in_last, out_ready,
        output in_ready, out_valid, out_q
    );
`endif
endinterface

// File: rtl/cim_tile_adder_tree.sv
// Registered binary adder tree for one output column; side-band flags ride alongside.
// Nodes form a heap: node i sums children 2i+1 and 2i+2, leaves occupy the tail.
module cim_tile_adder_tree
    import cim_tile_pkg::*;
#(
    parameter int IN_N = 16,
    parameter int IN_W = 16
) (
    input  logic                                 CLK,
    input  logic                                 NRST,
    input  logic                                 en,
    input  logic [IN_N*IN_W-1:0]                 in_data,
    input  sb_t                                  in_sb,
    output logic signed [IN_W+$clog2(IN_N)-1:0]  sum,
    output sb_t                                  out_sb
);
    localparam int S  = $clog2(IN_N);
    localparam int OW = IN_W + S;
    localparam int NN = IN_N - 1;

    logic signed [OW-1:0] all_s  [2*IN_N-1];
    logic signed [OW-1:0] node_r [NN];
    sb_t                  sb_r   [S];

    // Gather registered nodes and sign-extended leaves into one heap view.
    always_comb begin
        for (int i = 0; i < NN; i++) begin
            all_s[i] = node_r[i];
        end
        for (int j = 0; j < IN_N; j++) begin
            all_s[NN + j] = OW'($signed(in_data[j*IN_W +: IN_W]));
        end
    end

    // Tree node registers; every leaf sits at depth S so all paths see S stages.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < NN; i++) begin
                node_r[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NN; i++) begin
                node_r[i] <= all_s[2*i+1] + all_s[2*i+2];
            end
        end
    end

    // Side-band delay line matching the tree depth.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int k = 0; k < S; k++) begin
                sb_r[k] <= '0;
            end
        end else if (en) begin
            sb_r[0] <= in_sb;
            for (int k = 1; k < S; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
        end
    end

    assign sum    = node_r[0];
    assign out_sb = sb_r[S-1];

endmodule

// File: rtl/cim_tile_mac.sv
// CIM tile MAC: weight array, product stage, per-column adder trees, tile accumulators, output register.
// Define CIM_TILE_SAT_EN for saturating output reduction and the out_sat flags.
module cim_tile_mac
    import cim_tile_pkg::*;
#(
    parameter int ROW_NUM       = 16,
    parameter int COL_NUM       = 4,
    parameter int X_W           = 8,
    parameter int W_W           = 8,
    parameter int MEM_DEPTH     = 4,
    parameter int ACC_BEATS_MAX = 16,
    parameter int OUT_W         = 24
) (
    input  logic                            CLK,
    input  logic                            NRST,
    input  logic                            WEB,
    input  logic [$clog2(ROW_NUM)-1:0]      WROW,
    input  logic [col_aw(COL_NUM)-1:0]      WCOL,
    input  logic [$clog2(MEM_DEPTH)-1:0]    WADR,
    input  logic [W_W-1:0]                  WD,
    cim_tile_mac_if.slave                   bus
);
    localparam int PROD_W = prod_w(X_W, W_W);
    localparam int SUM_W  = sum_w(X_W, W_W, ROW_NUM);
    localparam int ACC_W  = acc_w(X_W, W_W, ROW_NUM, ACC_BEATS_MAX);

    logic [W_W-1:0]              wmem_r     [ROW_NUM][COL_NUM][MEM_DEPTH];
    logic signed [PROD_W-1:0]    prod_s     [COL_NUM][ROW_NUM];
    logic signed [PROD_W-1:0]    prod_r     [COL_NUM][ROW_NUM];
    sb_t                         p_sb_r;
    logic [ROW_NUM*PROD_W-1:0]   tree_in_s  [COL_NUM];
    logic signed [SUM_W-1:0]     sum_s      [COL_NUM];
    sb_t                         tree_sb_s  [COL_NUM];
    logic signed [ACC_W-1:0]     acc_r      [COL_NUM];
    logic signed [ACC_W-1:0]     acc_next_s [COL_NUM];
    logic [OUT_W-1:0]            out_s      [COL_NUM];
    logic                        out_valid_r;
    logic [COL_NUM*OUT_W-1:0]    out_q_r;
    logic                        en_s;
    logic                        accept_s;

    assign en_s          = !(out_valid_r && !bus.out_ready);
    assign accept_s      = bus.in_valid && en_s;
    assign bus.in_ready  = en_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_q     = out_q_r;

    // Weight array: write on WEB low regardless of stall; a same-edge beat sees the old word.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int r = 0; r < ROW_NUM; r++) begin
                for (int c = 0; c < COL_NUM; c++) begin
                    for (int d = 0; d < MEM_DEPTH; d++) begin
                        wmem_r[r][c][d] <= '0;
                    end
                end
            end
        end else if (!WEB && (int'(WCOL) < COL_NUM)) begin
            wmem_r[WROW][WCOL][WADR] <= WD;
        end
    end

    // Signed products of the presented beat against the selected weight set.
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            for (int r = 0; r < ROW_NUM; r++) begin
                prod_s[c][r] = PROD_W'($signed(bus.in_x[r*X_W +: X_W]))
                             * PROD_W'($signed(wmem_r[r][c][bus.in_adr]));
            end
        end
    end

    // Product stage; an idle cycle with the pipeline moving inserts a bubble.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            p_sb_r <= '0;
            for (int c = 0; c < COL_NUM; c++) begin
                for (int r = 0; r < ROW_NUM; r++) begin
                    prod_r[c][r] <= '0;
                end
            end
        end else if (en_s) begin
            if (accept_s) begin
                p_sb_r <= '{valid: 1'b1, first: bus.in_first, last: bus.in_last};
                prod_r <= prod_s;
            end else begin
                p_sb_r <= '0;
            end
        end
    end

    // Flatten each column's products for its tree.
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            tree_in_s[c] = '0;
            for (int r = 0; r < ROW_NUM; r++) begin
                tree_in_s[c][r*PROD_W +: PROD_W] = prod_r[c][r];
            end
        end
    end

    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
        cim_tile_adder_tree #(
            .IN_N (ROW_NUM),
            .IN_W (PROD_W)
        ) u_tree (
            .CLK     (CLK),
            .NRST    (NRST),
            .en      (en_s),
            .in_data (tree_in_s[c]),
            .in_sb   (p_sb_r),
            .sum     (sum_s[c]),
            .out_sb  (tree_sb_s[c])
        );
    end

    // Next accumulator value and its reduction to the output width.
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (tree_sb_s[c].first) begin
                acc_next_s[c] = ACC_W'(sum_s[c]);
            end else begin
                acc_next_s[c] = acc_r[c] + ACC_W'(sum_s[c]);
            end
`ifdef CIM_TILE_SAT_EN
            out_s[c] = OUT_W'(sat_val(64'(acc_next_s[c]), OUT_W));
`else
            out_s[c] = acc_next_s[c][OUT_W-1:0];
`endif
        end
    end

    // Tile accumulators; a non-first beat always builds on whatever is retained.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int c = 0; c < COL_NUM; c++) begin
                acc_r[c] <= '0;
            end
        end else if (en_s) begin
            for (int c = 0; c < COL_NUM; c++) begin
                if (tree_sb_s[c].valid) begin
                    acc_r[c] <= acc_next_s[c];
                end
            end
        end
    end

`ifdef CIM_TILE_SAT_EN
    logic [COL_NUM-1:0] out_sat_r;
    assign bus.out_sat = out_sat_r;

    // Clip flags captured together with the result word.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            out_sat_r <= '0;
        end else if (en_s) begin
            for (int c = 0; c < COL_NUM; c++) begin
                if (tree_sb_s[c].valid && tree_sb_s[c].last) begin
                    out_sat_r[c] <= sat_clip(64'(acc_next_s[c]), OUT_W);
                end
            end
        end
    end
`endif

    // Result register: pulses valid on tile completion, keeps the word otherwise.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            out_valid_r <= 1'b0;
            out_q_r     <= '0;
        end else if (en_s) begin
            out_valid_r <= tree_sb_s[0].valid && tree_sb_s[0].last;
            for (int c = 0; c < COL_NUM; c++) begin
                if (tree_sb_s[c].valid && tree_sb_s[c].last) begin
                    out_q_r[c*OUT_W +: OUT_W] <= out_s[c];
                end
            end
        end
    end

endmodule
